// File: rtl/demultiplexer_8x1.sv
// 1-to-8 demultiplexer with optional output register.
// Define DEMUX8X1_REG_OUT_EN to compile in the registered output stage.
module demultiplexer_8x1 #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   i,
  input  logic [2:0]          s,
  output logic [8*DATA_W-1:0] y
);

  logic [8*DATA_W-1:0] dec;

  // Unknown select falls to default so no channel sees X.
  always_comb begin
    dec = '0;
    case (s)
      3'd0: dec[0*DATA_W +: DATA_W] = i;
      3'd1: dec[1*DATA_W +: DATA_W] = i;
      3'd2: dec[2*DATA_W +: DATA_W] = i;
      3'd3: dec[3*DATA_W +: DATA_W] = i;
      3'd4: dec[4*DATA_W +: DATA_W] = i;
      3'd5: dec[5*DATA_W +: DATA_W] = i;
      3'd6: dec[6*DATA_W +: DATA_W] = i;
      3'd7: dec[7*DATA_W +: DATA_W] = i;
      default: dec = '0;
    endcase
  end

`ifdef DEMUX8X1_REG_OUT_EN
  logic [8*DATA_W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= dec;
  end

  assign y = q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign y = dec;
`endif

endmodule

// File: tb/tb_demultiplexer_8x1.sv
// Bench for demultiplexer_8x1, combinational or registered
// (DEMUX8X1_REG_OUT_EN) build, with DATA_W=1 and DATA_W=4.
module tb_demultiplexer_8x1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  i1 = '0;
  logic [3:0]  i4 = '0;
  logic [2:0]  s = '0;
  logic [7:0]  y1;
  logic [31:0] y4;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  demultiplexer_8x1 #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .i(i1), .s(s), .y(y1)
  );

  demultiplexer_8x1 #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(rst), .i(i4), .s(s), .y(y4)
  );

  // Data shifted to channel position; unknown select gives zero.
  function automatic logic [31:0] model(
    int w, logic [3:0] d, logic [2:0] sel, logic r
  );
`ifdef DEMUX8X1_REG_OUT_EN
    if (r) return 32'd0;
`endif
    if ($isunknown(sel)) return 32'd0;
    return 32'(d) << (w * int'(sel));
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive at negedge; comb build checks after settle,
  // registered build checks just after the next rising edge.
  task automatic step(
    string tag, logic d1, logic [3:0] d4, logic [2:0] sel, logic r
  );
    logic [31:0] e1, e4;
    @(negedge clk);
    i1 = d1;
    i4 = d4;
    s = sel;
    rst = r;
    e1 = model(1, {3'b0, d1}, sel, r);
    e4 = model(4, d4, sel, r);
`ifdef DEMUX8X1_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
    chk({tag, "_w1"}, {24'd0, y1}, e1);
    chk({tag, "_w4"}, y4, e4);
  endtask

  initial begin
    logic [2:0] sx;
    logic [1:0] fa;
    step("rst0", 1'b1, 4'h3, 3'd4, 1'b1);
    step("rst1", 1'b1, 4'h5, 3'd1, 1'b1);
    step("rel_s6", 1'b1, 4'h9, 3'd6, 1'b0);
    chk("rel_s6_lit", {24'd0, y1}, 32'h40);
    step("s2", 1'b1, 4'h9, 3'd2, 1'b0);
    chk("s2_lit", {24'd0, y1}, 32'h04);
    for (int k = 0; k < 8; k++) begin
      step("onehot", 1'b1, 4'hF, 3'(k), 1'b0);
      chk("onehot_lit", {24'd0, y1}, 32'h1 << k);
    end
    for (int k = 0; k < 8; k++) begin
      step("zero_i", 1'b0, 4'h0, 3'(k), 1'b0);
      chk("zero_i_lit", y4 | {24'd0, y1}, 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      step("fa_in", 1'b1, 4'h1, 3'(k), 1'b0);
      fa[0] = y1[1] | y1[2] | y1[4] | y1[7];
      fa[1] = y1[3] | y1[5] | y1[6] | y1[7];
      chk("fa_sum", {30'd0, fa}, 32'($countones(3'(k))));
    end
    step("w4_s5", 1'b1, 4'hA, 3'd5, 1'b0);
    chk("w4_s5_lit", y4, 32'h00A0_0000);
    sx = 3'bx1x;
    step("s_x", 1'b1, 4'hA, sx, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step("rand", 1'($urandom), 4'($urandom),
           3'($urandom_range(7)), 1'b0);
    end
    step("pre_rst", 1'b1, 4'h6, 3'd3, 1'b0);
    step("rst_s7", 1'b1, 4'hC, 3'd7, 1'b1);
    step("post_s7", 1'b1, 4'hC, 3'd7, 1'b0);
    chk("post_s7_lit", {24'd0, y1}, 32'h80);
    for (int k = 0; k < 20; k++) begin
      step("rand_rst", 1'($urandom), 4'($urandom),
           3'($urandom), ($urandom_range(3) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
